dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single-port 256x32 data memory (sync write, comb read).
//  Port 0 = CPU load/store path, port 1 = DMA/debug loader; one access granted per cycle.
//  Round-robin fairness, optional bus lock for multi-word bursts, bounded lock hold time.
//  Sits between the requesters and the memory; the memory shares rst/clk with this block.
// PARAMETERS
//  AW        8   requester address width; zero-extended to 32 bits on mem_addr
//  MAX_HOLD  8   max consecutive locked grants while the other port waits (>=1)
//  CW        16  statistics counter width (DMEM_ARB_STATS_EN only)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-low
//  rN_req      in   1   port N (N=0,1) access request, held until granted
//  rN_we       in   1   port N write (1) / read (0)
//  rN_lock     in   1   port N requests to keep ownership after this grant
//  rN_addr     in   AW  port N word address
//  rN_wdata    in   32  port N write data
//  rN_gnt      out  1   port N granted this cycle (combinational)
//  rN_rvalid   out  1   port N read data valid (registered, 1 cycle after read grant)
//  rN_rdata    out  32  port N read data, held until next read grant to N
//  mem_we      out  1   memory write enable
//  mem_addr    out  32  memory address {0, granted addr}
//  mem_wd      out  32  memory write data
//  mem_rd      in   32  memory combinational read data
// BEHAVIOUR
//  - Reset (rst=0): owner=IDLE, rr_ptr=0, hold_cnt=0, rvalid=0, rdata=0; gnt/mem_we forced 0.
//  - States: IDLE (no owner, round-robin), OWN0, OWN1 (locked to port 0/1).
//  - IDLE: only one req -> grant it; both -> grant port rr_ptr; after any grant rr_ptr = other port.
//  - Granted port with rN_lock=1 -> next state OWNn; lock=0 -> IDLE.
//  - OWNn: grant n whenever rN_req=1, regardless of other port; hold_cnt++ per grant while
//    other port requests, else hold_cnt cleared.
//  - OWNn exit: rN_lock=0 on a grant, or rN_req=0 (no grant) -> IDLE same edge; hold_cnt
//    reaching MAX_HOLD -> forced IDLE with rr_ptr=other port (other port wins next cycle).
//  - No grant -> mem_we=0, mem_addr/mem_wd=0. Exactly one gnt high max per cycle.
//  - Read: rdata of granted port <= mem_rd at grant edge; rvalid=1 for exactly next cycle.
//  - Write: mem_we=rN_we & rN_gnt; data commits at grant edge; rvalid stays 0.
//  - Read-after-write to same address in consecutive cycles returns the new data.
//  - Same-cycle requests never merge; the loser's req/addr must stay stable until granted.
//  - Reset asserted mid-burst: ownership dropped, pending rvalid discarded, no write issued.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs stat_gnt0, stat_gnt1, stat_wait1 (CW bits each):
//    grants per port, and cycles port 1 requested without grant; saturate at all-ones; reset 0.
//  Undefined: no stat ports, no counter logic; all other behaviour identical.
// STRUCTURE
//  Shared package dmem_pkg: owner_e enum {IDLE, OWN0, OWN1}, DMEM_DEPTH=256, DMEM_DW=32.
//  One sub-module natural: dmem_arb_port_rsp (rvalid/rdata register per port), instanced x2.
// TESTING
//  1. Reset, r0 write addr 5 data 0xDEADBEEF, then r0 read 5 -> r0_rvalid next cycle, rdata 0xDEADBEEF.
//  2. Both req every cycle, lock=0 -> grants alternate 0,1,0,1; no cycle with both gnt.
//  3. r0 lock=1 with 4 reads, r1 waiting, MAX_HOLD=8 -> r0 gets 4 in a row, r1 granted right after.
//  4. r0 lock held 20 cycles, r1 waiting, MAX_HOLD=8 -> 8 r0 grants, 1 r1 grant, r0 regains lock.
//  5. r1 write addr 9 with r0 read 9 same cycle, rr_ptr=1 -> r1 writes, r0 next cycle reads new value.
//  6. rst low mid-burst of OWN1 -> gnt/mem_we 0 immediately, rvalid 0, state IDLE, memory word 9 = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and memory geometry for the data-memory arbiter slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } owner_e;

    localparam int DMEM_DEPTH = 256;
    localparam int DMEM_DW    = 32;

endpackage

// File: rtl/dmem_arb_port_rsp.sv
// Per-port read response register: captures memory read data at a read grant
// and raises rvalid for the following cycle only.
module dmem_arb_port_rsp
    import dmem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               gnt,
    input  logic               we,
    input  logic [DMEM_DW-1:0] mem_rd,
    output logic               rvalid,
    output logic [DMEM_DW-1:0] rdata
);

    logic               rvalid_q, rvalid_d;
    logic [DMEM_DW-1:0] rdata_q, rdata_d;

    always_comb begin
        rvalid_d = gnt & ~we;
        rdata_d  = (gnt & ~we) ? mem_rd : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded bus lock in front of the 256x32 data memory.
// Define DMEM_ARB_STATS_EN to add saturating grant/wait statistics outputs.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW       = 8,
    parameter int MAX_HOLD = 8
`ifdef DMEM_ARB_STATS_EN
    ,
    parameter int CW       = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               r0_req,
    input  logic               r0_we,
    input  logic               r0_lock,
    input  logic [AW-1:0]      r0_addr,
    input  logic [DMEM_DW-1:0] r0_wdata,
    output logic               r0_gnt,
    output logic               r0_rvalid,
    output logic [DMEM_DW-1:0] r0_rdata,
    input  logic               r1_req,
    input  logic               r1_we,
    input  logic               r1_lock,
    input  logic [AW-1:0]      r1_addr,
    input  logic [DMEM_DW-1:0] r1_wdata,
    output logic               r1_gnt,
    output logic               r1_rvalid,
    output logic [DMEM_DW-1:0] r1_rdata,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [DMEM_DW-1:0] mem_wd,
    input  logic [DMEM_DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [CW-1:0]      stat_gnt0,
    output logic [CW-1:0]      stat_gnt1,
    output logic [CW-1:0]      stat_wait1
`endif
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    owner_e        owner_q, owner_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic          grant;
    logic          gsel;
    logic          g_lock;
    logic          other_req;
    logic [HW-1:0] cnt_base;
    logic [HW-1:0] cnt_inc;

    always_comb begin
        grant = 1'b0;
        gsel  = 1'b0;
        case (owner_q)
            OWN0: begin
                grant = r0_req;
                gsel  = 1'b0;
            end
            OWN1: begin
                grant = r1_req;
                gsel  = 1'b1;
            end
            default: begin
                grant = r0_req | r1_req;
                gsel  = (r0_req & r1_req) ? rr_ptr_q : r1_req;
            end
        endcase
    end

    // The grant that opens a lock counts toward MAX_HOLD, so a locked port
    // gets at most MAX_HOLD consecutive grants while the other port waits.
    always_comb begin
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        g_lock     = gsel ? r1_lock : r0_lock;
        other_req  = gsel ? r0_req : r1_req;
        cnt_base   = (owner_q == IDLE) ? '0 : hold_cnt_q;
        cnt_inc    = other_req ? cnt_base + HW'(1) : '0;
        if (grant) begin
            rr_ptr_d = ~gsel;
            if (g_lock && (cnt_inc < HW'(MAX_HOLD))) begin
                owner_d    = gsel ? OWN1 : OWN0;
                hold_cnt_d = cnt_inc;
            end else begin
                owner_d    = IDLE;
                hold_cnt_d = '0;
            end
        end else begin
            owner_d    = IDLE;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Grants are gated by rst so an asserted reset suppresses any access at once.
    assign r0_gnt   = rst & grant & ~gsel;
    assign r1_gnt   = rst & grant & gsel;
    assign mem_we   = (r0_gnt & r0_we) | (r1_gnt & r1_we);
    assign mem_addr = r1_gnt ? 32'(r1_addr) : (r0_gnt ? 32'(r0_addr) : '0);
    assign mem_wd   = r1_gnt ? r1_wdata : (r0_gnt ? r0_wdata : '0);

    dmem_arb_port_rsp u_rsp0 (
        .clk    (clk),
        .rst    (rst),
        .gnt    (r0_gnt),
        .we     (r0_we),
        .mem_rd (mem_rd),
        .rvalid (r0_rvalid),
        .rdata  (r0_rdata)
    );

    dmem_arb_port_rsp u_rsp1 (
        .clk    (clk),
        .rst    (rst),
        .gnt    (r1_gnt),
        .we     (r1_we),
        .mem_rd (mem_rd),
        .rvalid (r1_rvalid),
        .rdata  (r1_rdata)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [CW-1:0] stat_gnt0_q, stat_gnt0_d;
    logic [CW-1:0] stat_gnt1_q, stat_gnt1_d;
    logic [CW-1:0] stat_wait1_q, stat_wait1_d;

    always_comb begin
        stat_gnt0_d  = (r0_gnt && (stat_gnt0_q != '1)) ? stat_gnt0_q + 1'b1 : stat_gnt0_q;
        stat_gnt1_d  = (r1_gnt && (stat_gnt1_q != '1)) ? stat_gnt1_q + 1'b1 : stat_gnt1_q;
        stat_wait1_d = (r1_req && !r1_gnt && (stat_wait1_q != '1))
                       ? stat_wait1_q + 1'b1 : stat_wait1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_gnt0_q  <= '0;
            stat_gnt1_q  <= '0;
            stat_wait1_q <= '0;
        end else begin
            stat_gnt0_q  <= stat_gnt0_d;
            stat_gnt1_q  <= stat_gnt1_d;
            stat_wait1_q <= stat_wait1_d;
        end
    end

    assign stat_gnt0  = stat_gnt0_q;
    assign stat_gnt1  = stat_gnt1_q;
    assign stat_wait1 = stat_wait1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 256x32 memory.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk;
    logic        rst;
    logic        r0_req, r0_we, r0_lock;
    logic [7:0]  r0_addr;
    logic [31:0] r0_wdata;
    logic        r0_gnt, r0_rvalid;
    logic [31:0] r0_rdata;
    logic        r1_req, r1_we, r1_lock;
    logic [7:0]  r1_addr;
    logic [31:0] r1_wdata;
    logic        r1_gnt, r1_rvalid;
    logic [31:0] r1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] mem [DMEM_DEPTH];

    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wd;
    assign mem_rd = mem[mem_addr[7:0]];

    dmem_arbiter #(.AW(8), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_r0(input logic req, input logic we, input logic lock,
                          input logic [7:0] addr, input logic [31:0] wd);
        r0_req = req; r0_we = we; r0_lock = lock; r0_addr = addr; r0_wdata = wd;
    endtask

    task automatic set_r1(input logic req, input logic we, input logic lock,
                          input logic [7:0] addr, input logic [31:0] wd);
        r1_req = req; r1_we = we; r1_lock = lock; r1_addr = addr; r1_wdata = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_r0(1'b1, 1'b1, 1'b1, 8'd3, 32'h1111_1111);
        set_r1(1'b1, 1'b1, 1'b1, 8'd4, 32'h2222_2222);
        #2;
        n_vec++;
        if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin
            $display("FAIL reset_gnt r0_gnt=%b r1_gnt=%b expected 0/0", r0_gnt, r1_gnt); n_err++;
        end
        n_vec++;
        if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wd !== 32'd0) begin
            $display("FAIL reset_mem we=%b addr=%h wd=%h expected 0/0/0", mem_we, mem_addr, mem_wd); n_err++;
        end
        step();
        step();
        n_vec++;
        if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || r0_rdata !== 32'd0 || r1_rdata !== 32'd0) begin
            $display("FAIL reset_rsp rv0=%b rv1=%b rd0=%h rd1=%h expected 0", r0_rvalid, r1_rvalid,
                     r0_rdata, r1_rdata); n_err++;
        end
        set_r0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        set_r1(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        rst = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        set_r0(1'b1, 1'b1, 1'b0, 8'd5, 32'hDEAD_BEEF);
        #1;
        n_vec++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
            $display("FAIL wr_gnt r0_gnt=%b r1_gnt=%b expected 1/0", r0_gnt, r1_gnt); n_err++;
        end
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 32'd5 || mem_wd !== 32'hDEAD_BEEF) begin
            $display("FAIL wr_bus we=%b addr=%h wd=%h expected 1/5/deadbeef", mem_we, mem_addr, mem_wd); n_err++;
        end
        step();
        n_vec++;
        if (r0_rvalid !== 1'b0) begin
            $display("FAIL wr_rvalid got=%b expected 0", r0_rvalid); n_err++;
        end
        set_r0(1'b1, 1'b0, 1'b0, 8'd5, 32'd0);
        #1;
        n_vec++;
        if (r0_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd5) begin
            $display("FAIL rd_bus gnt=%b we=%b addr=%h expected 1/0/5", r0_gnt, mem_we, mem_addr); n_err++;
        end
        step();
        set_r0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        n_vec++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL rd_data rvalid=%b rdata=%h expected 1/deadbeef", r0_rvalid, r0_rdata); n_err++;
        end
        step();
        n_vec++;
        if (r0_rvalid !== 1'b0 || r0_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL rd_hold rvalid=%b rdata=%h expected 0/deadbeef", r0_rvalid, r0_rdata); n_err++;
        end
    endtask

    // rr_ptr is 1 after the single port-0 grant above, so port 1 wins first.
    task automatic test_round_robin();
        logic exp1;
        for (int c = 0; c < 6; c++) begin
            exp1 = ((c % 2) == 0);
            set_r0(1'b1, 1'b0, 1'b0, 8'd5, 32'd0);
            set_r1(1'b1, 1'b0, 1'b0, 8'd5, 32'd0);
            #1;
            n_vec++;
            if (r0_gnt !== ~exp1 || r1_gnt !== exp1) begin
                $display("FAIL rr_gnt cycle=%0d r0_gnt=%b r1_gnt=%b expected %b/%b", c, r0_gnt, r1_gnt,
                         ~exp1, exp1); n_err++;
            end
            step();
            n_vec++;
            if (r0_rvalid !== ~exp1 || r1_rvalid !== exp1) begin
                $display("FAIL rr_rvalid cycle=%0d rv0=%b rv1=%b expected %b/%b", c, r0_rvalid, r1_rvalid,
                         ~exp1, exp1); n_err++;
            end
        end
        set_r0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        set_r1(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        step();
    endtask

    task automatic test_lock_burst();
        logic [2:0] r0_req_t  = 3'b000;
        logic [4:0] exp0_tab  = 5'b01111;
        logic [4:0] exp1_tab  = 5'b10000;
        logic [4:0] r1req_tab = 5'b11110;
        logic [4:0] lock_tab  = 5'b00111;
        r0_req_t = 3'b000;
        for (int c = 0; c < 5; c++) begin
            set_r0(c < 4, 1'b0, lock_tab[c], 8'd5, 32'd0);
            set_r1(r1req_tab[c], 1'b0, 1'b0, 8'd5, 32'd0);
            #1;
            n_vec++;
            if (r0_gnt !== exp0_tab[c] || r1_gnt !== exp1_tab[c]) begin
                $display("FAIL lock_gnt cycle=%0d r0_gnt=%b r1_gnt=%b expected %b/%b", c, r0_gnt, r1_gnt,
                         exp0_tab[c], exp1_tab[c]); n_err++;
            end
            step();
        end
        n_vec++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL lock_r1_data rvalid=%b rdata=%h expected 1/deadbeef", r1_rvalid, r1_rdata); n_err++;
        end
        set_r0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        set_r1(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        step();
    endtask

    // Port 0 holds lock throughout; hold limit expires at cycles 7 and 19.
    task automatic test_max_hold();
        logic e1;
        logic e0;
        for (int c = 0; c < 22; c++) begin
            set_r0(c <= 20, 1'b0, 1'b1, 8'd5, 32'd0);
            set_r1((c <= 8) || (c >= 12 && c <= 20), 1'b0, 1'b0, 8'd5, 32'd0);
            e1 = (c == 8) || (c == 20);
            e0 = (c <= 19) && !e1;
            #1;
            n_vec++;
            if (r0_gnt !== e0 || r1_gnt !== e1) begin
                $display("FAIL hold_gnt cycle=%0d r0_gnt=%b r1_gnt=%b expected %b/%b", c, r0_gnt, r1_gnt,
                         e0, e1); n_err++;
            end
            if (c == 21) begin
                n_vec++;
                if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wd !== 32'd0) begin
                    $display("FAIL idle_bus we=%b addr=%h wd=%h expected 0/0/0", mem_we, mem_addr, mem_wd);
                    n_err++;
                end
            end
            step();
        end
        set_r0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        set_r1(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic test_raw_collision();
        set_r0(1'b1, 1'b0, 1'b0, 8'd5, 32'd0);
        step();
        set_r0(1'b1, 1'b0, 1'b0, 8'd9, 32'd0);
        set_r1(1'b1, 1'b1, 1'b0, 8'd9, 32'h1234_5678);
        #1;
        n_vec++;
        if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'd9) begin
            $display("FAIL raw_wr r0_gnt=%b r1_gnt=%b we=%b addr=%h expected 0/1/1/9", r0_gnt, r1_gnt,
                     mem_we, mem_addr); n_err++;
        end
        step();
        set_r1(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        #1;
        n_vec++;
        if (r0_gnt !== 1'b1 || r1_rvalid !== 1'b0) begin
            $display("FAIL raw_rd_gnt r0_gnt=%b r1_rvalid=%b expected 1/0", r0_gnt, r1_rvalid); n_err++;
        end
        step();
        set_r0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        n_vec++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h1234_5678) begin
            $display("FAIL raw_data rvalid=%b rdata=%h expected 1/12345678", r0_rvalid, r0_rdata); n_err++;
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        set_r0(1'b1, 1'b1, 1'b0, 8'd9, 32'd0);
        step();
        set_r0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        set_r1(1'b1, 1'b0, 1'b1, 8'd5, 32'd0);
        step();
        n_vec++;
        if (r1_rvalid !== 1'b1) begin
            $display("FAIL burst_rvalid got=%b expected 1", r1_rvalid); n_err++;
        end
        set_r1(1'b1, 1'b1, 1'b1, 8'd9, 32'hBAD0_BAD0);
        #1;
        n_vec++;
        if (r1_gnt !== 1'b1 || mem_we !== 1'b1) begin
            $display("FAIL burst_wr gnt=%b we=%b expected 1/1", r1_gnt, mem_we); n_err++;
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (r1_gnt !== 1'b0 || r0_gnt !== 1'b0 || mem_we !== 1'b0) begin
            $display("FAIL rst_gnt r0_gnt=%b r1_gnt=%b we=%b expected 0/0/0", r0_gnt, r1_gnt, mem_we); n_err++;
        end
        n_vec++;
        if (r1_rvalid !== 1'b0 || r1_rdata !== 32'd0) begin
            $display("FAIL rst_rsp rvalid=%b rdata=%h expected 0/0", r1_rvalid, r1_rdata); n_err++;
        end
        step();
        step();
        n_vec++;
        if (mem[9] !== 32'd0) begin
            $display("FAIL rst_nowrite mem9=%h expected 0", mem[9]); n_err++;
        end
        set_r0(1'b1, 1'b0, 1'b0, 8'd9, 32'd0);
        set_r1(1'b1, 1'b0, 1'b0, 8'd5, 32'd0);
        rst = 1'b1;
        #1;
        n_vec++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
            $display("FAIL rst_idle r0_gnt=%b r1_gnt=%b expected 1/0", r0_gnt, r1_gnt); n_err++;
        end
        step();
        set_r0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        set_r1(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        n_vec++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd0) begin
            $display("FAIL rst_read9 rvalid=%b rdata=%h expected 1/0", r0_rvalid, r0_rdata); n_err++;
        end
        step();
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock_burst();
        test_max_hold();
        test_raw_collision();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
